// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide sequencer.
package ex_muldiv_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MUL_RUN = 2'b01,
    DIV_RUN = 2'b10,
    DONE    = 2'b11
  } state_t;

endpackage

// File: rtl/ex_muldiv_ctrl_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
module muldiv_step
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 mode,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   shl_s;
  logic [WIDTH:0]       diff_s;
  logic                 ge_s;

  // Multiply keeps {partial, multiplier} and shifts right; divide keeps {rem, quo} and shifts left.
  always_comb begin
    sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shl_s    = {acc[2*WIDTH-2:0], 1'b0};
    diff_s   = {1'b0, shl_s[2*WIDTH-1:WIDTH]} - {1'b0, opnd};
    // The bit shifted out of rem is its (W+1)th bit, so it alone guarantees rem >= divisor.
    ge_s     = acc[2*WIDTH-1] | ~diff_s[WIDTH];
    acc_next = acc;
    if (mode == MODE_MUL) begin
      acc_next = {sum_s, acc[WIDTH-1:1]};
    end else if (ge_s) begin
      acc_next = {diff_s[WIDTH-1:0], shl_s[WIDTH-1:1], 1'b1};
    end else begin
      acc_next = shl_s;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MUL/DIV sequencer: owns the FSM, iteration counter, operands and Hi/Lo.
module ex_muldiv_ctrl
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             kill,
  output logic             freeze,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t               state_r;
  state_t               state_nx_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   acc_nx_s;
  logic [WIDTH-1:0]     opnd_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  logic                 div_zero_r;
  logic                 done_r;
  logic                 busy_r;
  logic                 op_valid_s;
  logic                 accept_s;
  logic                 run_s;
  logic                 last_s;
  logic                 mode_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode     (mode_s),
    .acc      (acc_r),
    .opnd     (opnd_r),
    .acc_next (acc_nx_s)
  );

  // Acceptance, run-phase decode and the stall request seen by ID/EX.
  always_comb begin
    op_valid_s = (op_sel == OP_MUL) || (op_sel == OP_DIV);
    accept_s   = (state_r == IDLE) && start && op_valid_s && !kill;
    run_s      = (state_r == MUL_RUN) || (state_r == DIV_RUN);
    mode_s     = (state_r == DIV_RUN) ? MODE_DIV : MODE_MUL;
    last_s     = (cnt_r == CNT_W'(WIDTH - 1));
    freeze     = accept_s || run_s;
  end

  // Next-state logic; DONE always returns to IDLE so start is never re-sampled there.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = (op_sel == OP_MUL) ? MUL_RUN : DIV_RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (kill) begin
          state_nx_s = IDLE;
        end else if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = state_r;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register with registered status flags derived from the next state.
  always_ff @(posedge clk) begin
    if (rest) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == MUL_RUN) || (state_nx_s == DIV_RUN);
      done_r  <= (state_nx_s == DONE);
    end
  end

  // Operand capture, iteration datapath, and the Hi/Lo commit on the last run cycle.
  always_ff @(posedge clk) begin
    if (rest) begin
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      opnd_r     <= {WIDTH{1'b0}};
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      div_zero_r <= 1'b0;
    end else if (accept_s) begin
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {{WIDTH{1'b0}}, (op_sel == OP_MUL) ? src_b : src_a};
      opnd_r     <= (op_sel == OP_MUL) ? src_a : src_b;
      div_zero_r <= 1'b0;
    end else if (run_s && !kill) begin
      acc_r <= acc_nx_s;
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (last_s) begin
        hi_r       <= acc_nx_s[2*WIDTH-1:WIDTH];
        lo_r       <= acc_nx_s[WIDTH-1:0];
        div_zero_r <= (mode_s == MODE_DIV) && (opnd_r == {WIDTH{1'b0}});
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule
